// File: rtl/fir_xifu_issue_buf.sv
// Issue buffer for the FIR extension unit: decodes XIF issue requests, answers the
// issue response, tracks a register scoreboard and queues accepted work for EX.
module fir_xifu_issue_buf #(
    parameter int         DEPTH    = 4,
    parameter int         ID_WIDTH = 4,
    parameter logic [6:0] OPCODE   = 7'h0B,
    parameter int         NREG     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_instr_i,
    input  logic [31:0]              issue_rs0_i,
    input  logic [ID_WIDTH-1:0]      issue_id_i,
    output logic                     issue_accept_o,
    output logic                     issue_writeback_o,
    output logic                     issue_loadstore_o,
    output logic                     ex_valid_o,
    input  logic                     ex_ready_i,
    output logic [1:0]               ex_instr_o,
    output logic [31:0]              ex_base_o,
    output logic [31:0]              ex_offset_o,
    output logic [4:0]               ex_rs1_o,
    output logic [4:0]               ex_rs2_o,
    output logic [4:0]               ex_rd_o,
    output logic [ID_WIDTH-1:0]      ex_id_o,
    input  logic                     wb_valid_i,
    input  logic [4:0]               wb_rd_i,
    input  logic                     kill_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        CODE_INVALID = 2'd0,
        CODE_LW      = 2'd1,
        CODE_SW      = 2'd2,
        CODE_DOTP    = 2'd3
    } code_e;

    typedef struct packed {
        code_e               code;
        logic [31:0]         base;
        logic [31:0]         offset;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [ID_WIDTH-1:0] id;
    } entry_t;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [NREG-1:0]  busy_q, busy_d;
    entry_t           mem_q [DEPTH];

    code_e      code;
    logic [4:0] rd, rs1, rs2;
    logic       supported, hazard, full, ls_type, push, pop;
    entry_t     new_entry, head;

    assign rd  = issue_instr_i[11:7];
    assign rs1 = issue_instr_i[19:15];
    assign rs2 = issue_instr_i[24:20];

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        code = CODE_INVALID;
        if (issue_instr_i[6:0] == OPCODE) begin
            case (issue_instr_i[14:12])
                3'd0:    code = CODE_LW;
                3'd1:    code = CODE_SW;
                3'd2:    code = CODE_DOTP;
                default: code = CODE_INVALID;
            endcase
        end
    end

    always_comb begin
        hazard = 1'b0;
        case (code)
            CODE_LW:   hazard = busy_q[rd];
            CODE_SW:   hazard = busy_q[rs2];
            CODE_DOTP: hazard = busy_q[rs1] | busy_q[rs2];
            default:   hazard = 1'b0;
        endcase
    end

    // Readiness looks only at registered occupancy and scoreboard, never at this cycle's pop or writeback.
    assign full              = (count_q == CNT_W'(DEPTH));
    assign supported         = (code != CODE_INVALID);
    assign ls_type           = (code == CODE_LW) || (code == CODE_SW);
    assign issue_ready_o     = !full && !kill_i && !(supported && hazard);
    assign issue_accept_o    = issue_valid_i && supported;
    assign issue_writeback_o = issue_valid_i && ls_type;
    assign issue_loadstore_o = issue_valid_i && ls_type;
    assign push              = issue_accept_o && issue_ready_o;
    assign pop               = ex_valid_o && ex_ready_i;

    always_comb begin
        new_entry      = '0;
        new_entry.code = code;
        new_entry.base = issue_rs0_i;
        new_entry.rs1  = rs1;
        new_entry.rs2  = rs2;
        new_entry.rd   = rd;
        new_entry.id   = issue_id_i;
        case (code)
            CODE_LW: new_entry.offset = {{20{issue_instr_i[31]}}, issue_instr_i[31:20]};
            CODE_SW: new_entry.offset = {{20{issue_instr_i[31]}}, issue_instr_i[31:25], issue_instr_i[11:7]};
            default: new_entry.offset = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        busy_d   = busy_q;
        if (kill_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            busy_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (wb_valid_i && (int'(wb_rd_i) < NREG)) busy_d[wb_rd_i] = 1'b0;
            // A load claims its destination after any writeback clear in the same cycle.
            if (push && (code == CODE_LW)) busy_d[rd] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    // NOTE: entry storage is not reset; the head is masked while empty so stale data never escapes.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

    assign ex_valid_o  = (count_q != '0);
    assign head        = ex_valid_o ? mem_q[rd_ptr_q] : '0;
    assign ex_instr_o  = head.code;
    assign ex_base_o   = head.base;
    assign ex_offset_o = head.offset;
    assign ex_rs1_o    = head.rs1;
    assign ex_rs2_o    = head.rs2;
    assign ex_rd_o     = head.rd;
    assign ex_id_o     = head.id;
    assign count_o     = count_q;

endmodule

// File: tb/tb_fir_xifu_issue_buf.sv
// Bench for fir_xifu_issue_buf: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_fir_xifu_issue_buf;

    localparam int DEPTH    = 4;
    localparam int ID_WIDTH = 4;
    localparam int NREG     = 32;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic                clk, rst_n;
    logic                issue_valid, issue_ready, ex_valid, ex_ready;
    logic [31:0]         issue_instr, issue_rs0;
    logic [ID_WIDTH-1:0] issue_id, ex_id;
    logic                acc_o, wbk_o, lsu_o;
    logic [1:0]          ex_instr;
    logic [31:0]         ex_base, ex_offset;
    logic [4:0]          ex_rs1, ex_rs2, ex_rd, wb_rd;
    logic                wb_valid, kill;
    logic [CNT_W-1:0]    count;

    fir_xifu_issue_buf #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .OPCODE(7'h0B), .NREG(NREG)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_instr_i(issue_instr), .issue_rs0_i(issue_rs0), .issue_id_i(issue_id),
        .issue_accept_o(acc_o), .issue_writeback_o(wbk_o), .issue_loadstore_o(lsu_o),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
        .ex_instr_o(ex_instr), .ex_base_o(ex_base), .ex_offset_o(ex_offset),
        .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_id_o(ex_id),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .kill_i(kill), .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'd0, rd, 7'h0B};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'd1, imm[4:0], 7'h0B};
    endfunction

    function automatic logic [31:0] enc_dotp(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd2, rd, 7'h0B};
    endfunction

    // Reference model: an ordered list of pending entries and a set of busy registers.
    typedef struct {
        logic [1:0]          code;
        logic [31:0]         base;
        logic [31:0]         off;
        logic [4:0]          rs1, rs2, rd;
        logic [ID_WIDTH-1:0] id;
    } ent_t;

    ent_t mq[$];
    bit   m_busy[NREG];

    function automatic logic [1:0] m_code(input logic [31:0] ins);
        if (ins[6:0] != 7'h0B) return 2'd0;
        if (ins[14:12] == 3'd0) return 2'd1;
        if (ins[14:12] == 3'd1) return 2'd2;
        if (ins[14:12] == 3'd2) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic m_hazard(input logic [31:0] ins);
        logic [1:0] c;
        c = m_code(ins);
        if (c == 2'd1) return m_busy[ins[11:7]];
        if (c == 2'd2) return m_busy[ins[24:20]];
        if (c == 2'd3) return m_busy[ins[19:15]] || m_busy[ins[24:20]];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        logic [1:0] c;
        logic       sup, rdy, acc, lsx;
        ent_t       hd, e;
        if (!rst_n) begin
            mq.delete();
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end
        c   = m_code(issue_instr);
        sup = (c != 2'd0);
        rdy = (mq.size() < DEPTH) && !kill && !(sup && m_hazard(issue_instr));
        acc = issue_valid && sup;
        lsx = issue_valid && (c == 2'd1 || c == 2'd2);
        hd  = '{code: 2'd0, base: 32'd0, off: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, id: '0};
        if (mq.size() > 0) hd = mq[0];
        check("m_ready", issue_ready, rdy);
        check("m_accept", acc_o, acc);
        check("m_writeback", wbk_o, lsx);
        check("m_loadstore", lsu_o, lsx);
        check("m_count", count, mq.size());
        check("m_ex_valid", ex_valid, mq.size() > 0);
        check("m_ex_instr", ex_instr, hd.code);
        check("m_ex_base", ex_base, hd.base);
        check("m_ex_offset", ex_offset, hd.off);
        check("m_ex_rs1", ex_rs1, hd.rs1);
        check("m_ex_rs2", ex_rs2, hd.rs2);
        check("m_ex_rd", ex_rd, hd.rd);
        check("m_ex_id", ex_id, hd.id);
        if (rst_n) begin
            if (kill) begin
                mq.delete();
                foreach (m_busy[i]) m_busy[i] = 1'b0;
            end else begin
                if (mq.size() > 0 && ex_ready) void'(mq.pop_front());
                if (wb_valid) m_busy[wb_rd] = 1'b0;
                if (acc && rdy) begin
                    e.code = c;
                    e.base = issue_rs0;
                    e.rs1  = issue_instr[19:15];
                    e.rs2  = issue_instr[24:20];
                    e.rd   = issue_instr[11:7];
                    e.id   = issue_id;
                    if (c == 2'd1)      e.off = 32'($signed(issue_instr[31:20]));
                    else if (c == 2'd2) e.off = 32'($signed({issue_instr[31:25], issue_instr[11:7]}));
                    else                e.off = 32'd0;
                    mq.push_back(e);
                    if (c == 2'd1) m_busy[issue_instr[11:7]] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        int          sel;
        rst_n = 1'b0; issue_valid = 1'b0; issue_instr = '0; issue_rs0 = '0; issue_id = '0;
        ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; kill = 1'b0;

        tick(); tick(); #1;
        check("rst_count", count, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ready", issue_ready, 1);
        check("rst_accept", acc_o, 0);
        check("rst_ex_base", ex_base, 0);
        tick();
        rst_n = 1'b1;

        // Load with negative immediate, then a dot product that depends on its destination.
        tick();
        ex_ready = 1'b1; issue_valid = 1'b1; issue_instr = enc_lw(5'd3, 5'd1, 12'hFFC);
        issue_rs0 = 32'h1000; issue_id = 4'd0; #1;
        check("lw_accept", acc_o, 1);
        check("lw_writeback", wbk_o, 1);
        check("lw_loadstore", lsu_o, 1);
        check("lw_ready", issue_ready, 1);
        tick();
        issue_valid = 1'b0; #1;
        check("lw_ex_valid", ex_valid, 1);
        check("lw_ex_offset", ex_offset, 32'hFFFF_FFFC);
        check("lw_ex_base", ex_base, 32'h1000);
        check("lw_ex_instr", ex_instr, 1);
        check("lw_ex_rd", ex_rd, 3);
        issue_valid = 1'b1; issue_instr = enc_dotp(5'd7, 5'd3, 5'd4); issue_id = 4'd1; #1;
        check("dotp_blocked", issue_ready, 0);
        tick(); #1;
        check("dotp_still_blocked", issue_ready, 0);
        check("lw_popped", count, 0);
        wb_valid = 1'b1; wb_rd = 5'd3; #1;
        check("dotp_no_bypass", issue_ready, 0);
        tick();
        wb_valid = 1'b0; #1;
        check("dotp_ready", issue_ready, 1);
        check("dotp_accept", acc_o, 1);
        check("dotp_writeback", wbk_o, 0);
        check("dotp_loadstore", lsu_o, 0);
        tick();
        issue_valid = 1'b0; #1;
        check("dotp_count", count, 1);
        check("dotp_ex_instr", ex_instr, 3);
        check("dotp_ex_offset", ex_offset, 0);
        check("dotp_ex_rs1", ex_rs1, 3);
        check("dotp_ex_rs2", ex_rs2, 4);
        check("dotp_ex_rd", ex_rd, 7);
        check("dotp_ex_id", ex_id, 1);
        tick(); #1;
        check("dotp_drained", count, 0);

        // Fill with stores while EX stalls; the fifth must be refused.
        ex_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1;
            issue_instr = enc_sw(5'(i + 1), 5'(i + 8), (i == 3) ? 12'h800 : 12'(i * 4));
            issue_id = 4'(i); issue_rs0 = 32'h2000 + 32'(i); #1;
            check("fill_ready", issue_ready, (i < 4) ? 1 : 0);
            check("fill_accept", acc_o, 1);
            tick();
        end
        #1;
        check("full_count", count, 4);
        issue_id = 4'd9; ex_ready = 1'b1; #1;
        check("full_push_pop_ready", issue_ready, 0);
        check("head_id0", ex_id, 0);
        tick(); #1;
        check("pop_only_count", count, 3);
        check("head_id1", ex_id, 1);
        issue_valid = 1'b0;
        tick(); #1;
        check("count2", count, 2);
        check("head_id2", ex_id, 2);
        check("head2_base", ex_base, 32'h2002);
        check("head2_offset", ex_offset, 32'h8);
        check("head2_rs2", ex_rs2, 10);
        issue_valid = 1'b1; issue_instr = enc_sw(5'd1, 5'd2, 12'd0); issue_id = 4'd10; #1;
        check("pp_ready", issue_ready, 1);
        tick();
        issue_valid = 1'b0; #1;
        check("pp_count", count, 2);
        check("head_id3", ex_id, 3);
        check("head3_offset", ex_offset, 32'hFFFF_F800);
        check("head3_base", ex_base, 32'h2003);
        tick(); #1;
        check("head_id10", ex_id, 10);
        check("count1", count, 1);
        tick(); #1;
        check("empty_again", ex_valid, 0);

        // Unsupported instructions are refused without being queued.
        issue_valid = 1'b1; issue_instr = {17'd0, 3'd7, 5'd1, 7'h0B}; #1;
        check("bad_f3_ready", issue_ready, 1);
        check("bad_f3_accept", acc_o, 0);
        check("bad_f3_wb", wbk_o, 0);
        tick();
        issue_instr = {25'd0, 7'h33}; #1;
        check("bad_op_ready", issue_ready, 1);
        check("bad_op_accept", acc_o, 0);
        tick();
        issue_valid = 1'b0; #1;
        check("bad_count", count, 0);

        // Kill with three queued entries and a live scoreboard bit.
        ex_ready = 1'b0; issue_valid = 1'b1;
        issue_instr = enc_lw(5'd5, 5'd1, 12'd0); issue_id = 4'd0; tick();
        issue_instr = enc_sw(5'd1, 5'd2, 12'd4); issue_id = 4'd1; tick();
        issue_instr = enc_sw(5'd2, 5'd3, 12'd8); issue_id = 4'd2; tick(); #1;
        check("pre_kill_count", count, 3);
        kill = 1'b1; issue_instr = enc_sw(5'd1, 5'd6, 12'd0); #1;
        check("kill_ready", issue_ready, 0);
        tick();
        kill = 1'b0; issue_valid = 1'b0; #1;
        check("kill_count", count, 0);
        check("kill_ex_valid", ex_valid, 0);
        issue_valid = 1'b1; issue_instr = enc_lw(5'd5, 5'd0, 12'd0); #1;
        check("kill_busy_cleared", issue_ready, 1);
        tick();
        issue_valid = 1'b0; #1;
        check("relaunch_count", count, 1);
        wb_valid = 1'b1; wb_rd = 5'd5; ex_ready = 1'b1;
        tick();
        wb_valid = 1'b0;
        tick(); #1;
        check("relaunch_drained", count, 0);

        // Reset in the middle of traffic clears the queue without waiting for an edge.
        ex_ready = 1'b0; issue_valid = 1'b1; issue_instr = enc_sw(5'd1, 5'd2, 12'd0);
        tick(); tick();
        issue_valid = 1'b0; #1;
        check("pre_reset_count", count, 2);
        rst_n = 1'b0; #1;
        check("async_reset_count", count, 0);
        check("async_reset_ex_valid", ex_valid, 0);
        tick(); tick();
        rst_n = 1'b1;

        // Random traffic; the negedge model comparison does the checking.
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            r   = $urandom;
            if (sel <= 2)      issue_instr = enc_lw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[11:0]);
            else if (sel <= 5) issue_instr = enc_sw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[11:0]);
            else if (sel <= 7) issue_instr = enc_dotp(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                                      5'($urandom_range(0, 7)));
            else if (sel == 8) begin
                r[6:0] = 7'h0B; r[14:12] = 3'($urandom_range(3, 7));
                issue_instr = r;
            end else begin
                if (r[6:0] == 7'h0B) r[6:0] = 7'h33;
                issue_instr = r;
            end
            issue_valid = ($urandom % 4) != 0;
            issue_rs0   = $urandom;
            issue_id    = ID_WIDTH'($urandom);
            ex_ready    = ($urandom % 3) != 0;
            wb_valid    = ($urandom % 4) == 0;
            wb_rd       = 5'($urandom_range(0, 7));
            kill        = ($urandom % 60) == 0;
            tick();
        end
        issue_valid = 1'b0; ex_ready = 1'b1; wb_valid = 1'b0; kill = 1'b0;
        repeat (8) tick();
        #1;
        check("final_drained", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_xifu_issue_buf.md
FIR_XIFU_ISSUE_BUF -- requirements
Module: fir_xifu_issue_buf

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-002 Parameter ID_WIDTH, default 4, width of the XIF instruction id.
REQ-003 Parameter OPCODE, default 7'h0B, major opcode owned by the XIFU.
REQ-004 Parameter NREG, default 32, number of XIFU registers tracked by the scoreboard.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 issue_valid_i  in  1; issue_ready_o  out  1  XIF issue handshake.
REQ-008 issue_instr_i  in  32; issue_rs0_i  in  32; issue_id_i  in  ID_WIDTH  issue payload.
REQ-009 issue_accept_o, issue_writeback_o, issue_loadstore_o  out  1 each  issue response.
REQ-010 ex_valid_o  out  1; ex_ready_i  in  1  queue-to-EX handshake.
REQ-011 ex_instr_o 2, ex_base_o 32, ex_offset_o 32, ex_rs1_o 5, ex_rs2_o 5, ex_rd_o 5, ex_id_o ID_WIDTH  out  head-entry payload.
REQ-012 wb_valid_i  in  1; wb_rd_i  in  5  XIFU register writeback, clears the scoreboard.
REQ-013 kill_i  in  1  flush of all queued and in-flight work.
REQ-014 count_o  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-015 Decode: opcode = instr[6:0], funct3 = instr[14:12], rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20].
REQ-016 Supported: funct3 0 = XFIRLW (code 1), funct3 1 = XFIRSW (code 2), funct3 2 = XFIRDOTP (code 3); all else INVALID (code 0).
REQ-017 Response is combinational from issue inputs and is valid only while issue_valid_i = 1; all three response bits are 0 when issue_valid_i = 0.
REQ-018 XFIRLW and XFIRSW: accept = writeback = loadstore = 1; XFIRDOTP: accept = 1, writeback = loadstore = 0; INVALID or opcode mismatch: all 0.
REQ-019 Hazard: XFIRLW reads none and writes rd; XFIRSW reads rs2; XFIRDOTP reads rs1 and rs2; hazard = any read or written register has its busy bit set.
REQ-020 issue_ready_o = !full & !kill_i & !(supported & hazard); for unsupported instructions it is !full & !kill_i, a rejection handshake that pushes nothing.
REQ-021 full and hazard use registered state only; there is no same-cycle bypass from ex_ready_i or wb_valid_i.
REQ-022 Push occurs when issue_valid_i & issue_ready_o & accept; the entry is {code, base = rs0, offset, rs1, rs2, rd, id}.
REQ-023 Offset is the sign-extended S-immediate {instr[31:25], instr[11:7]} for XFIRSW, the sign-extended I-immediate instr[31:20] for XFIRLW, and 0 for XFIRDOTP.
REQ-024 A push of XFIRLW sets busy[rd] in the same edge.
REQ-025 wb_valid_i clears busy[wb_rd_i]; a writeback to a non-busy register is ignored.
REQ-026 The queue is FIFO; ex_valid_o = (count != 0); ex_* reflects the oldest entry, registered, with no combinational path from issue inputs.
REQ-027 Pop occurs when ex_valid_o & ex_ready_i; simultaneous push and pop leaves count unchanged and preserves order.
REQ-028 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-029 ex_* payload is held stable while ex_valid_o = 1 and ex_ready_i = 0.
REQ-030 kill_i: at the next edge count = 0, pointers = 0, and all busy bits = 0; push, pop and wb in the kill cycle are discarded.

Reset
REQ-031 While rst_ni = 0: count_o = 0, ex_valid_o = 0, ex_* = 0, all busy bits = 0, pointers = 0.
REQ-032 issue_ready_o = 1 and the response bits are 0 during reset, since no issue is valid; state cannot change until rst_ni is deasserted.
REQ-033 Reset asserted mid-operation discards queue contents immediately and asynchronously.

Verification
REQ-034 Issue XFIRLW (rd = 3, imm = 12'hFFC, rs0 = 32'h1000) with ex_ready_i = 1 -> accept = wb = ls = 1; next cycle ex_valid_o = 1, ex_offset_o = 32'hFFFF_FFFC, ex_base_o = 32'h1000, busy[3] = 1.
REQ-035 Then issue XFIRDOTP with rs1 = 3 -> issue_ready_o = 0 until wb_valid_i with wb_rd_i = 3; the cycle after, issue_ready_o = 1 and the push occurs.
REQ-036 Hold ex_ready_i = 0 and issue DEPTH+1 distinct XFIRSW -> count_o = 4, issue_ready_o = 0 on the fifth; releasing ex_ready_i pops in issue order with ids 0..3.
REQ-037 At count_o = 4 assert push and pop in the same cycle (ready drops to 0, so only the pop occurs) -> count_o = 3; then push and pop together at count_o = 2 -> count_o stays 2 with order intact.
REQ-038 Issue funct3 = 7 and opcode 7'h33 -> issue_ready_o = 1, accept = 0, count_o unchanged.
REQ-039 With count_o = 3 and busy[5] = 1, assert kill_i together with a valid issue -> issue_ready_o = 0; next cycle count_o = 0, ex_valid_o = 0, busy[5] = 0.
